cpc_romsel_ctrl: RTL and testbench



---
 rtl/cpc_romsel_ctrl.sv | 142 ++++++++++++++
 tb/tb_cpc_romsel_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_romsel_ctrl.sv
// cpc_romsel_ctrl: CPC upper-ROM bank controller. Latches the ROM number written
// to I/O &DFxx (A13 low), drives one active-low chip select per local slot plus
// ROMDIS, and gates EEPROM writes behind a 55/AA/01 key sequence on the config port.
// Latency: slot latch and unlock state update one rising CLK edge after the first
// strobe cycle; chip selects, ROMDIS and rom_we_b are combinational from that state.
// Backpressure: none; each bus strobe acts once, however many cycles it is held.
// Ports: CLK/RESET (sync, active high); A, D, IOREQ_B, MREQ_B, WR_B, RD_B Z80 bus;
// SLOT_EN per-slot DIP enables; romcs_b, ROMDIS, rom_we_b, unlocked outputs.
// Optional macro SLOT_READBACK_EN adds d_out/d_oe readback of rom_sel and FSM state.
module cpc_romsel_ctrl #(
    parameter int         NUM_SLOTS   = 8,
    parameter int         SLOT_BASE   = 0,
    parameter logic [7:0] CFG_PORT_HI = 8'hFC
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [15:0]          A,
    input  logic [7:0]           D,
    input  logic                 IOREQ_B,
    input  logic                 MREQ_B,
    input  logic                 WR_B,
    input  logic                 RD_B,
    input  logic [NUM_SLOTS-1:0] SLOT_EN,
    output logic [NUM_SLOTS-1:0] romcs_b,
    output logic                 ROMDIS,
    output logic                 rom_we_b,
`ifdef SLOT_READBACK_EN
    output logic [7:0]           d_out,
    output logic                 d_oe,
`endif
    output logic                 unlocked
);

    // The config port must decode with A13 high so it can never alias &DFxx.
    if (CFG_PORT_HI[5] != 1'b1) begin : g_bad_cfg_port
        $error("CFG_PORT_HI bit 5 must be 1");
    end
    if (NUM_SLOTS < 1 || NUM_SLOTS > 16) begin : g_bad_num_slots
        $error("NUM_SLOTS must be 1..16");
    end
    if (SLOT_BASE < 0 || SLOT_BASE + NUM_SLOTS - 1 > 255) begin : g_bad_slot_base
        $error("SLOT_BASE+NUM_SLOTS-1 must be <= 255");
    end

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        KEY1     = 2'd1,
        KEY2     = 2'd2,
        UNLOCKED = 2'd3
    } state_t;

    state_t               state;
    logic [7:0]           rom_sel;
    logic                 sel_stb;
    logic                 cfg_stb;
    logic                 sel_q;
    logic                 cfg_q;
    logic                 sel_fire;
    logic                 cfg_fire;
    logic [NUM_SLOTS-1:0] hit_vec;
    logic                 hit;

    assign sel_stb  = ~IOREQ_B & ~WR_B & ~A[13];
    assign cfg_stb  = ~IOREQ_B & ~WR_B & (A[15:8] == CFG_PORT_HI);
    // Act only on the leading cycle of a strobe.
    assign sel_fire = sel_stb & ~sel_q;
    assign cfg_fire = cfg_stb & ~cfg_q;

    // Per-slot match in 9 bits so SLOT_BASE+i never wraps past 255; a selection
    // outside the window simply matches no slot.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit_vec[i] = SLOT_EN[i] & ({1'b0, rom_sel} == 9'(SLOT_BASE + i));
        end
    end

    assign hit      = |hit_vec;
    assign romcs_b  = ~hit_vec;
    assign ROMDIS   = hit;
    assign rom_we_b = ~(unlocked & hit & ~MREQ_B & ~WR_B & (A[15:14] == 2'b11));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sel_q    <= 1'b0;
            cfg_q    <= 1'b0;
            rom_sel  <= 8'h00;
            state    <= LOCKED;
            unlocked <= 1'b0;
        end else begin
            sel_q <= sel_stb;
            cfg_q <= cfg_stb;
            if (sel_fire) begin
                rom_sel <= D;
            end
            // cfg_fire and sel_fire cannot coincide (disjoint decodes), so the
            // key step takes precedence over the slot-write abort.
            if (cfg_fire) begin
                case (state)
                    LOCKED: begin
                        if (D == 8'h55) state <= KEY1;
                    end
                    KEY1: begin
                        state <= (D == 8'hAA) ? KEY2 : LOCKED;
                    end
                    KEY2: begin
                        if (D == 8'h01) begin
                            state    <= UNLOCKED;
                            unlocked <= 1'b1;
                        end else begin
                            state <= LOCKED;
                        end
                    end
                    UNLOCKED: begin
                        if (D == 8'h00) begin
                            state    <= LOCKED;
                            unlocked <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= LOCKED;
                        unlocked <= 1'b0;
                    end
                endcase
            end else if (sel_fire && (state == KEY1 || state == KEY2)) begin
                // A slot write in the middle of the key sequence aborts it.
                state <= LOCKED;
            end
        end
    end

`ifdef SLOT_READBACK_EN
    assign d_oe  = ~IOREQ_B & ~RD_B & (A[15:8] == CFG_PORT_HI);
    assign d_out = A[0] ? {6'b0, state} : rom_sel;
    logic unused_bits;
    assign unused_bits = ^A[7:1];
`else
    logic unused_bits;
    assign unused_bits = ^{A[7:0], RD_B};
`endif

endmodule

// File: tb/tb_cpc_romsel_ctrl.sv
module tb_cpc_romsel_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] A;
    logic [7:0]  D;
    logic        IOREQ_B, MREQ_B, WR_B, RD_B;
    logic [7:0]  en0, en8;
    logic [7:0]  cs0, cs8;
    logic        romdis0, romdis8, we0, we8, unl0, unl8;
`ifdef SLOT_READBACK_EN
    logic [7:0]  dout0, dout8;
    logic        doe0, doe8;
`endif

    always #5 CLK = ~CLK;

    cpc_romsel_ctrl #(.NUM_SLOTS(8), .SLOT_BASE(0), .CFG_PORT_HI(8'hFC)) dut (
        .CLK(CLK), .RESET(RESET), .A(A), .D(D), .IOREQ_B(IOREQ_B), .MREQ_B(MREQ_B),
        .WR_B(WR_B), .RD_B(RD_B), .SLOT_EN(en0), .romcs_b(cs0), .ROMDIS(romdis0),
        .rom_we_b(we0),
`ifdef SLOT_READBACK_EN
        .d_out(dout0), .d_oe(doe0),
`endif
        .unlocked(unl0));

    cpc_romsel_ctrl #(.NUM_SLOTS(8), .SLOT_BASE(8), .CFG_PORT_HI(8'hFC)) dut8 (
        .CLK(CLK), .RESET(RESET), .A(A), .D(D), .IOREQ_B(IOREQ_B), .MREQ_B(MREQ_B),
        .WR_B(WR_B), .RD_B(RD_B), .SLOT_EN(en8), .romcs_b(cs8), .ROMDIS(romdis8),
        .rom_we_b(we8),
`ifdef SLOT_READBACK_EN
        .d_out(dout8), .d_oe(doe8),
`endif
        .unlocked(unl8));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: selected ROM number and count of key bytes matched (3 = unlocked).
    logic [7:0] m_sel;
    int         m_prog;
    logic [7:0] keys [3] = '{8'h55, 8'hAA, 8'h01};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_hit(input int base, input logic [7:0] en, input logic [7:0] sel);
        int s;
        s = int'(sel);
        if (s >= base && s < base + 8) return en[s - base];
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_cs(input int base, input logic [7:0] en, input logic [7:0] sel);
        logic [7:0] one;
        one = 8'd1;
        if (exp_hit(base, en, sel)) return ~(one << (int'(sel) - base));
        return 8'hFF;
    endfunction

    function automatic logic exp_we(input logic [15:0] addr, input int base, input logic [7:0] en);
        return ~((m_prog == 3) && exp_hit(base, en, m_sel) && (addr[15:14] == 2'b11));
    endfunction

    task automatic model_io(input logic [15:0] addr, input logic [7:0] d);
        if (!addr[13]) begin
            m_sel = d;
            if (m_prog == 1 || m_prog == 2) m_prog = 0;
        end
        if (addr[15:8] == 8'hFC) begin
            if (m_prog == 3) begin
                if (d == 8'h00) m_prog = 0;
            end else if (d == keys[m_prog]) begin
                m_prog++;
            end else begin
                m_prog = 0;
            end
        end
    endtask

    task automatic idle_bus();
        A = 16'h0000; D = 8'h00;
        IOREQ_B = 1'b1; MREQ_B = 1'b1; WR_B = 1'b1; RD_B = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        m_sel = 8'h00;
        m_prog = 0;
    endtask

    task automatic io_wr(input logic [15:0] addr, input logic [7:0] d, input int cycles);
        @(negedge CLK);
        A = addr; D = d; IOREQ_B = 1'b0; WR_B = 1'b0;
        repeat (cycles) @(negedge CLK);
        IOREQ_B = 1'b1; WR_B = 1'b1;
        model_io(addr, d);
    endtask

    task automatic check_state();
        check("romcs_b_base0", cs0, exp_cs(0, en0, m_sel));
        check("romdis_base0", romdis0, exp_hit(0, en0, m_sel));
        check("romcs_b_base8", cs8, exp_cs(8, en8, m_sel));
        check("romdis_base8", romdis8, exp_hit(8, en8, m_sel));
        check("unlocked_base0", unl0, m_prog == 3);
        check("unlocked_base8", unl8, m_prog == 3);
        check("we_idle", {we0, we8}, 2'b11);
    endtask

    task automatic mem_wr(input logic [15:0] addr);
        @(negedge CLK);
        A = addr; MREQ_B = 1'b0; WR_B = 1'b1;
        #1 check("we_before_wr", {we0, we8}, 2'b11);
        @(negedge CLK);
        WR_B = 1'b0;
        repeat (2) begin
            #1 check("we_during_wr0", we0, exp_we(addr, 0, en0));
            check("we_during_wr8", we8, exp_we(addr, 8, en8));
            @(negedge CLK);
        end
        WR_B = 1'b1;
        #1 check("we_after_wr", {we0, we8}, 2'b11);
        @(negedge CLK);
        MREQ_B = 1'b1;
    endtask

    initial begin
        idle_bus();
        RESET = 1'b1;
        en0 = 8'hFF;
        en8 = 8'hFF;
        m_sel = 8'h00;
        m_prog = 0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1 check("reset_romcs_b", cs0, 8'hFE);
        check("reset_romdis", romdis0, 1'b1);
        check_state();

        // OUT &DF00,3
        io_wr(16'hDF00, 8'd3, 1);
        check("sel3_romcs_b", cs0, 8'b1111_0111);
        check_state();

        // OUT &DF00,9: outside base-0 window; masked in base-8 build with 8'hFD
        io_wr(16'hDF00, 8'd9, 1);
        check("sel9_romcs_b", cs0, 8'hFF);
        check("sel9_romdis", romdis0, 1'b0);
        en8 = 8'hFD;
        #1 check("sel9_masked_cs", cs8, 8'hFF);
        check("sel9_masked_romdis", romdis8, 1'b0);
        en8 = 8'hFF;
        #1 check("sel9_unmasked_cs", cs8, 8'hFD);
        check_state();

        // Strobe held 5 cycles, D changes 2 -> 5 mid-strobe: first cycle wins
        @(negedge CLK);
        A = 16'hDF00; D = 8'd2; IOREQ_B = 1'b0; WR_B = 1'b0;
        @(negedge CLK);
        D = 8'd5;
        repeat (4) @(negedge CLK);
        IOREQ_B = 1'b1; WR_B = 1'b1;
        model_io(16'hDF00, 8'd2);
        check("held_strobe_cs", cs0, 8'hFB);
        check_state();

        // Unlock, EEPROM write gated by WR_B, relock
        io_wr(16'hDF00, 8'd3, 1);
        io_wr(16'hFC00, 8'h55, 1);
        io_wr(16'hFC00, 8'hAA, 2);
        io_wr(16'hFC00, 8'h01, 1);
        check("unlock_seq", unl0, 1'b1);
        check_state();
        mem_wr(16'hC123);
        io_wr(16'hFC00, 8'h00, 1);
        check("relock", unl0, 1'b0);
        mem_wr(16'hC123);

        // Broken key sequences
        io_wr(16'hFC00, 8'h55, 1);
        io_wr(16'hFC00, 8'h12, 1);
        io_wr(16'hFC00, 8'hAA, 1);
        io_wr(16'hFC00, 8'h01, 1);
        check("bad_key_seq", unl0, 1'b0);
        io_wr(16'hFC00, 8'h55, 1);
        io_wr(16'hFC00, 8'hAA, 1);
        do_reset();
        io_wr(16'hFC00, 8'h01, 1);
        check("reset_mid_seq", unl0, 1'b0);
        check_state();
        io_wr(16'hFC00, 8'h55, 1);
        io_wr(16'hDF00, 8'd4, 1);
        io_wr(16'hFC00, 8'hAA, 1);
        io_wr(16'hFC00, 8'h01, 1);
        check("sel_abort_seq", unl0, 1'b0);
        check_state();

        // Reset wins over a simultaneous slot write
        @(negedge CLK);
        A = 16'hDF00; D = 8'd7; IOREQ_B = 1'b0; WR_B = 1'b0; RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; IOREQ_B = 1'b1; WR_B = 1'b1;
        m_sel = 8'h00; m_prog = 0;
        check("reset_beats_strobe", cs0, 8'hFE);
        check_state();

`ifdef SLOT_READBACK_EN
        io_wr(16'hDF00, 8'd6, 1);
        io_wr(16'hFC00, 8'h55, 1);
        io_wr(16'hFC00, 8'hAA, 1);
        @(negedge CLK);
        #1 check("doe_idle", doe0, 1'b0);
        A = 16'hFC00; IOREQ_B = 1'b0; RD_B = 1'b0;
        #1 check("rb_sel", dout0, 8'd6);
        check("rb_doe", doe0, 1'b1);
        A = 16'hFC01;
        #1 check("rb_state", dout0, 8'd2);
        @(negedge CLK);
        IOREQ_B = 1'b1; RD_B = 1'b1;
        #1 check("doe_released", doe0, 1'b0);
        io_wr(16'hFC00, 8'h00, 1);
        model_io(16'hFC00, 8'h00);
        check_state();
`endif

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            int op;
            logic [15:0] addr;
            op = $urandom_range(0, 6);
            case (op)
                0: begin
                    addr = 16'($urandom) & 16'hDFFF;
                    io_wr(addr, 8'($urandom_range(0, 20)), $urandom_range(1, 3));
                end
                1: begin
                    logic [7:0] d;
                    case ($urandom_range(0, 4))
                        0: d = 8'h55;
                        1: d = 8'hAA;
                        2: d = 8'h01;
                        3: d = 8'h00;
                        default: d = 8'($urandom);
                    endcase
                    io_wr({8'hFC, 8'($urandom)}, d, $urandom_range(1, 3));
                end
                2: begin
                    io_wr(16'hFC00, 8'h55, 1);
                    io_wr(16'hFC00, 8'hAA, 1);
                    io_wr(16'hFC00, 8'h01, 1);
                end
                3: begin
                    addr = 16'($urandom) | 16'h2000;
                    io_wr(addr, 8'($urandom), 1);
                end
                4: begin
                    addr = 16'($urandom);
                    if ($urandom_range(0, 1) == 1) addr[15:14] = 2'b11;
                    mem_wr(addr);
                end
                5: begin
                    en0 = 8'($urandom);
                    en8 = 8'($urandom);
                    #1;
                end
                default: begin
                    if ($urandom_range(0, 7) == 0) do_reset();
                    else @(negedge CLK);
                end
            endcase
            check_state();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
